rotabit_trail_pwm: RTL and testbench

//   Downstream consumer of the rotabit 16-bit pattern x. Gives each lit bit a

---
 rtl/rotabit_pkg.sv | 14 +
 rtl/trail_cell.sv | 47 ++++
 rtl/rotabit_trail_pwm.sv | 84 ++++++++
 tb/tb_rotabit_trail_pwm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rotabit_pkg.sv
// Shared defaults and helpers for the rotabit pattern path and its LED trail stage.
package rotabit_pkg;

  localparam int N_DEF  = 16;
  localparam int BW_DEF = 4;

  typedef logic [BW_DEF-1:0] level_t;

  // Full-brightness level for a given level width.
  function automatic int lvl_max(input int bw);
    return (32'sd1 << bw) - 32'sd1;
  endfunction

endpackage

// File: rtl/trail_cell.sv
// One LED of the comet trail: brightness level register with load/decay update
// and a registered PWM compare against the shared frame counter.
module trail_cell
  import rotabit_pkg::*;
#(
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          decay_tick,
  input  logic [BW-1:0] pwm_cnt,
  output logic          led
);

  localparam logic [BW-1:0] LVL_MAX = BW'(lvl_max(BW));

  logic [BW-1:0] level_r;
  logic [BW-1:0] level_nxt_s;
  logic          led_r;

  // Load wins over decay; decay saturates at zero.
  always_comb begin
    level_nxt_s = level_r;
    if (load) begin
      level_nxt_s = LVL_MAX;
    end else if (decay_tick && (level_r != {BW{1'b0}})) begin
      level_nxt_s = level_r - {{(BW-1){1'b0}}, 1'b1};
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Level register and PWM output flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_r <= {BW{1'b0}};
      led_r   <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      led_r   <= (pwm_cnt < level_r);
    end
  end

  assign led = led_r;

endmodule

// File: rtl/rotabit_trail_pwm.sv
// Comet-trail fader between the rotabit core and the LED pins: samples the
// pattern, owns the decay prescaler and PWM frame counter, and fans out to cells.
module rotabit_trail_pwm
  import rotabit_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int BW        = BW_DEF,
  parameter int DECAY_DIV = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] x_in,
  output logic [N-1:0] led,
  output logic         frame_tick
);

  localparam int            DW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DECAY_DIV - 1);
  localparam logic [BW-1:0] PWM_LAST = BW'(lvl_max(BW) - 1);

  logic [N-1:0]  x_q_r;
  logic [DW-1:0] div_cnt_r;
  logic [BW-1:0] pwm_cnt_r;
  logic          frame_tick_r;
  logic          decay_tick_s;

  assign decay_tick_s = en && (div_cnt_r == DIV_LAST);

  // Pattern input register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q_r <= {N{1'b0}};
    end else begin
      x_q_r <= x_in;
    end
  end

  // Decay prescaler: runs only while enabled, otherwise holds its count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= {DW{1'b0}};
    end else if (en) begin
      if (decay_tick_s) begin
        div_cnt_r <= {DW{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + {{(DW-1){1'b0}}, 1'b1};
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // PWM frame counter and wrap pulse, independent of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_r    <= {BW{1'b0}};
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= (pwm_cnt_r == PWM_LAST);
      if (pwm_cnt_r == PWM_LAST) begin
        pwm_cnt_r <= {BW{1'b0}};
      end else begin
        pwm_cnt_r <= pwm_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    trail_cell #(
      .BW(BW)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .load       (x_q_r[i]),
      .decay_tick (decay_tick_s),
      .pwm_cnt    (pwm_cnt_r),
      .led        (led[i])
    );
  end

  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_rotabit_trail_pwm.sv
// Directed bench for rotabit_trail_pwm (N=16, BW=4, DECAY_DIV=4): vector tables
// for the per-cycle LED/frame behaviour plus duty-count sequences for the corners.
module tb_rotabit_trail_pwm;

  localparam int N   = 16;
  localparam int BW  = 4;
  localparam int DIV = 4;

  typedef struct {
    logic        en;
    logic [15:0] x;
    logic [15:0] led;
    logic        ft;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] x_in = 16'h0000;
  logic [15:0] led;
  logic        frame_tick;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  rotabit_trail_pwm #(
    .N         (N),
    .BW        (BW),
    .DECAY_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .x_in       (x_in),
    .led        (led),
    .frame_tick (frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Level of bit 0 after edge j for a single-cycle load at edge 1, decay frozen after edge f.
  function automatic int lvl_a(input int j, input int f);
    int jj;
    int l;
    jj = (j < f) ? j : f;
    if (jj < 2) return 0;
    if (jj < 4) return 15;
    l = 15 - jj / 4;
    return (l > 0) ? l : 0;
  endfunction

  task automatic fill_trail(input int kmax, input int f);
    for (int k = 1; k <= kmax; k++) begin
      vq.push_back('{en: (k <= f), x: (k == 1) ? 16'h0001 : 16'h0000,
                     led: {15'h0000, (((k - 1) % 15) < lvl_a(k - 1, f))},
                     ft: ((k % 15) == 0)});
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      en   = vq[i].en;
      x_in = vq[i].x;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] led", tag, i + 1), {16'h0000, led}, {16'h0000, vq[i].led});
      check($sformatf("%s[%0d] frame_tick", tag, i + 1), {31'h0, frame_tick}, {31'h0, vq[i].ft});
    end
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    en   = 1'b0;
    x_in = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input logic e, input logic [15:0] x);
    en   = e;
    x_in = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int ftc;
    int cnts[16];
    int exp_l;

    // Reset state
    #12;
    check("reset led", {16'h0000, led}, 32'h0);
    check("reset frame_tick", {31'h0, frame_tick}, 32'h0);

    // All bits held on: dark for two edges, then fully lit; frame pulse every 15
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      vq.push_back('{en: 1'b0, x: 16'hFFFF, led: (k >= 3) ? 16'hFFFF : 16'h0000,
                     ft: ((k % 15) == 0)});
    end
    run_table("allon");

    // Single-cycle pulse on bit 0, decaying to dark by edge 60
    do_reset();
    fill_trail(70, 1000);
    run_table("trail");

    // Freeze at level 9, then async reset between edges
    do_reset();
    fill_trail(31, 24);
    run_table("pre_rst");
    #3;
    rst = 1'b0;
    #1;
    check("async reset led", {16'h0000, led}, 32'h0);
    check("async reset frame_tick", {31'h0, frame_tick}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      vq.push_back('{en: 1'b0, x: 16'h0000, led: 16'h0000, ft: ((k % 15) == 0)});
    end
    run_table("post_rst");

    // Reload of bit 3 on the same edge as a decay tick while at level 7
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      step(1'b1, (k == 1 || k == 35) ? 16'h0008 : 16'h0000);
    end
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 16'h0000);
      cnt += int'(led[3]);
    end
    check("load beats decay duty", cnt, 15);

    // en low freezes decay at level 10; prescaler resumes from its held count
    do_reset();
    step(1'b1, 16'h0020);
    for (int k = 2; k <= 22; k++) step(1'b1, 16'h0000);
    cnt = 0;
    ftc = 0;
    for (int k = 0; k < 105; k++) begin
      step(1'b0, 16'h0000);
      cnt += int'(led[5]);
      ftc += int'(frame_tick);
    end
    check("frozen duty 105 cycles", cnt, 70);
    check("frame_tick while frozen", ftc, 7);
    step(1'b1, 16'h0000);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 16'h0000);
      cnt += int'(led[5]);
    end
    check("no early decrement", cnt, 10);
    step(1'b1, 16'h0000);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 16'h0000);
      cnt += int'(led[5]);
    end
    check("decrement after held count", cnt, 9);

    // Walking head, one position per 8 cycles, then freeze and measure the trail
    do_reset();
    for (int p = 0; p < 10; p++) begin
      for (int r = 0; r < 8; r++) step(1'b1, 16'(1) << p);
    end
    step(1'b0, 16'h0000);
    for (int b = 0; b < 16; b++) cnts[b] = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 16'h0000);
      for (int b = 0; b < 16; b++) cnts[b] += int'(led[b]);
    end
    for (int b = 0; b < 16; b++) begin
      if (b == 9) exp_l = 15;
      else if (b < 9) exp_l = (2 * b - 3 > 0) ? 2 * b - 3 : 0;
      else exp_l = 0;
      check($sformatf("walk duty bit%0d", b), cnts[b], exp_l);
    end
    check("walk ordering", {31'h0, (cnts[9] > cnts[8]) && (cnts[8] > cnts[7])}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
